// File: rtl/io_strobe_latch.sv
// I/O slot strobe latch: detects select falling edges, updates the
// scroll/latch/sound registers, and runs a kickable watchdog.
module io_strobe_latch #(
    parameter int unsigned WDOG_LIMIT = 4096,
    parameter int unsigned WD_PULSE   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] cs_n,
    input  logic [2:0] a,
    input  logic [7:0] din,
    output logic [7:0] scroll,
    output logic [7:0] latch,
    output logic       snd_wr,
    output logic [7:0] snd_data,
    output logic       irq_ack,
    output logic       wd_reset
);

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PULSE_W = 8;
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(WDOG_LIMIT - 1);
    localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(WD_PULSE - 1);

    typedef enum logic [0:0] {
        ST_COUNT = 1'b0,
        ST_PULSE = 1'b1
    } wd_state_e;

    wd_state_e          wd_state_q, wd_state_d;
    logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [PULSE_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic               wd_reset_q, wd_reset_d;

    logic [7:0] cs_q;
    logic [7:0] strobe_c;
    logic [7:0] scroll_q, scroll_d;
    logic [7:0] latch_q, latch_d;
    logic [7:0] snd_data_q, snd_data_d;
    logic       snd_wr_q, snd_wr_d;
    logic       irq_ack_q, irq_ack_d;

    // Falling edge of a select: high at the previous edge, low now.
    assign strobe_c = cs_q & ~cs_n;

    always_comb begin
        scroll_d   = scroll_q;
        latch_d    = latch_q;
        snd_data_d = snd_data_q;
        snd_wr_d   = strobe_c[2];
        irq_ack_d  = strobe_c[4];
        if (strobe_c[0]) scroll_d   = din;
        if (strobe_c[1]) latch_d[a] = din[0];
        if (strobe_c[2]) snd_data_d = din;
    end

    // Watchdog: count idle cycles, then hold wd_reset for WD_PULSE cycles.
    always_comb begin
        wd_state_d  = wd_state_q;
        wd_cnt_d    = wd_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        wd_reset_d  = wd_reset_q;
        case (wd_state_q)
            ST_COUNT: begin
                if (strobe_c[3]) begin
                    wd_cnt_d = '0;
                end else if (wd_cnt_q == CNT_LAST) begin
                    wd_state_d  = ST_PULSE;
                    wd_cnt_d    = '0;
                    pulse_cnt_d = PULSE_LAST;
                    wd_reset_d  = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end
            ST_PULSE: begin
                wd_cnt_d = '0;
                if (pulse_cnt_q == '0) begin
                    wd_state_d = ST_COUNT;
                    wd_reset_d = 1'b0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - PULSE_W'(1);
                end
            end
            default: begin
                wd_state_d = ST_COUNT;
                wd_cnt_d   = '0;
                wd_reset_d = 1'b0;
            end
        endcase
    end

    // cs_q tracks cs_n even in reset so a held select cannot strobe on release.
    always_ff @(posedge clk) begin
        cs_q <= cs_n;
        if (reset) begin
            scroll_q    <= '0;
            latch_q     <= '0;
            snd_data_q  <= '0;
            snd_wr_q    <= 1'b0;
            irq_ack_q   <= 1'b0;
            wd_state_q  <= ST_COUNT;
            wd_cnt_q    <= '0;
            pulse_cnt_q <= '0;
            wd_reset_q  <= 1'b0;
        end else begin
            scroll_q    <= scroll_d;
            latch_q     <= latch_d;
            snd_data_q  <= snd_data_d;
            snd_wr_q    <= snd_wr_d;
            irq_ack_q   <= irq_ack_d;
            wd_state_q  <= wd_state_d;
            wd_cnt_q    <= wd_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            wd_reset_q  <= wd_reset_d;
        end
    end

    assign scroll   = scroll_q;
    assign latch    = latch_q;
    assign snd_wr   = snd_wr_q;
    assign snd_data = snd_data_q;
    assign irq_ack  = irq_ack_q;
    assign wd_reset = wd_reset_q;

endmodule

// File: tb/tb_io_strobe_latch.sv
// Directed bench for io_strobe_latch with a short watchdog (limit 8, pulse 3).
module tb_io_strobe_latch;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cs_n;
    logic [2:0] a;
    logic [7:0] din;
    logic [7:0] scroll;
    logic [7:0] latch;
    logic       snd_wr;
    logic [7:0] snd_data;
    logic       irq_ack;
    logic       wd_reset;

    int n_checks = 0;
    int n_pass   = 0;

    io_strobe_latch #(
        .WDOG_LIMIT(8),
        .WD_PULSE  (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs_n    (cs_n),
        .a       (a),
        .din     (din),
        .scroll  (scroll),
        .latch   (latch),
        .snd_wr  (snd_wr),
        .snd_data(snd_data),
        .irq_ack (irq_ack),
        .wd_reset(wd_reset)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock edge, then settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cs_n  = 8'hFF;
        a     = 3'd0;
        din   = 8'h00;
        tick();
        tick();
        check("rst_scroll",   scroll,          8'h00);
        check("rst_latch",    latch,           8'h00);
        check("rst_snd_data", snd_data,        8'h00);
        check("rst_snd_wr",   8'(snd_wr),      8'h00);
        check("rst_irq_ack",  8'(irq_ack),     8'h00);
        check("rst_wd_reset", 8'(wd_reset),    8'h00);

        // Free-running watchdog: pulses on cycles 8..10, 19..21, ...
        reset = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            check($sformatf("wd_free_%0d", k), 8'(wd_reset),
                  8'((k >= 8) && (((k - 8) % 11) < 3)));
        end

        // Kick exactly at wd_cnt == 7 suppresses the pulse.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 8) cs_n = 8'hF7;
            else        cs_n = 8'hFF;
            tick();
            check($sformatf("wd_kick_%0d", k), 8'(wd_reset), 8'(k == 16));
        end

        // Reset mid-pulse with slot 0 held low across release.
        reset = 1'b1;
        cs_n  = 8'hFE;
        din   = 8'h77;
        tick();
        check("mid_pulse_drop", 8'(wd_reset), 8'h00);
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("held_no_strobe", scroll, 8'h00);
        end
        cs_n = 8'hFF;
        tick();
        check("rearm_high", scroll, 8'h00);
        cs_n = 8'hFE;
        tick();
        check("rearm_low", scroll, 8'h77);
        cs_n = 8'hFF;
        tick();

        // Slot 0: single write while held for three cycles.
        din  = 8'h5A;
        cs_n = 8'hFE;
        tick();
        check("scroll_write", scroll, 8'h5A);
        din = 8'h11;
        tick();
        tick();
        check("scroll_hold", scroll, 8'h5A);
        cs_n = 8'hFF;
        tick();

        // Slot 1: addressable bit latch.
        a = 3'd5; din = 8'h01; cs_n = 8'hFD;
        tick();
        check("latch_set5", latch, 8'h20);
        cs_n = 8'hFF;
        tick();
        a = 3'd2; din = 8'h01; cs_n = 8'hFD;
        tick();
        check("latch_set2", latch, 8'h24);
        cs_n = 8'hFF;
        tick();
        a = 3'd5; din = 8'h00; cs_n = 8'hFD;
        tick();
        check("latch_clr5", latch, 8'h04);
        cs_n = 8'hFF;
        tick();

        // Slot 2: sound write strobe held four cycles.
        din  = 8'hC3;
        cs_n = 8'hFB;
        tick();
        check("snd_data", snd_data, 8'hC3);
        check("snd_wr_hi", 8'(snd_wr), 8'h01);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("snd_wr_lo", 8'(snd_wr), 8'h00);
        end
        cs_n = 8'hFF;
        tick();

        // Slot 4: interrupt acknowledge.
        cs_n = 8'hEF;
        tick();
        check("irq_ack_hi", 8'(irq_ack), 8'h01);
        tick();
        check("irq_ack_lo", 8'(irq_ack), 8'h00);
        cs_n = 8'hFF;
        tick();

        // Simultaneous slots 0,1,2,4.
        din = 8'hA5; a = 3'd7; cs_n = 8'hE8;
        tick();
        check("multi_scroll",   scroll,       8'hA5);
        check("multi_latch",    latch,        8'h84);
        check("multi_snd_data", snd_data,     8'hA5);
        check("multi_snd_wr",   8'(snd_wr),   8'h01);
        check("multi_irq_ack",  8'(irq_ack),  8'h01);
        cs_n = 8'hFF;
        tick();

        // Slots 5..7 do nothing.
        din = 8'h00; a = 3'd2; cs_n = 8'h1F;
        tick();
        check("s567_scroll", scroll, 8'hA5);
        check("s567_latch",  latch,  8'h84);
        check("s567_snd_wr", 8'(snd_wr), 8'h00);
        cs_n = 8'hFF;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
